// File: rtl/noc_params.sv
// Shared NoC router parameters and the port direction type used across the router.
package noc_params;

    localparam int VC_NUM   = 2;
    localparam int PORT_NUM = 5;
    localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter: the search starts at the pointer, and the pointer moves
// past the winner only when the caller confirms that the grant was used.
module round_robin_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request_i,
    input  logic         update_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] grant_idx_o
);

    logic [W-1:0] ptr_q, ptr_d;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        int  idx;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && request_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = W'(idx);
            end
        end
    end

    // Kept apart from the grant logic: update_i is itself derived from grant_o downstream.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i && (|grant_o)) begin
            ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/switch_allocator.sv
// Two-stage separable switch allocator: a round-robin VC pick per input, then a
// round-robin input pick per output. Grants are combinational and appear in the same cycle.
module switch_allocator
    import noc_params::*;
#(
    parameter int VC_NUM   = noc_params::VC_NUM,
    parameter int PORT_NUM = noc_params::PORT_NUM,
    localparam int PW      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]   request_i,
    input  port_t                             out_port_i      [PORT_NUM][VC_NUM],
    input  logic [VC_SIZE-1:0]                downstream_vc_i [PORT_NUM][VC_NUM],
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]   on_off_i,
    output logic [PORT_NUM-1:0]               valid_o,
    output logic [VC_SIZE-1:0]                sel_vc_o        [PORT_NUM],
    output port_t                             xb_sel_o        [PORT_NUM],
    output logic [PORT_NUM-1:0]               valid_flit_o
);

    logic [VC_NUM-1:0]   elig     [PORT_NUM];
    logic [VC_NUM-1:0]   vc_gnt   [PORT_NUM];
    logic [VC_SIZE-1:0]  s1_vc    [PORT_NUM];
    logic [PORT_NUM-1:0] s1_valid;
    port_t               s1_port  [PORT_NUM];
    logic [PORT_NUM-1:0] in_req   [PORT_NUM];
    logic [PORT_NUM-1:0] in_gnt   [PORT_NUM];
    logic [PW-1:0]       in_idx   [PORT_NUM];

    // Gating eligibility with rst silences every grant while reset is held.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                elig[i][v] = !rst && request_i[i][v]
                             && on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            s1_valid[i] = |vc_gnt[i];
            s1_port[i]  = out_port_i[i][s1_vc[i]];
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                in_req[o][i] = s1_valid[i] && (int'(s1_port[i]) == o);
            end
        end
    end

    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            valid_flit_o[o] = |in_gnt[o];
            xb_sel_o[o]     = valid_flit_o[o] ? port_t'(in_idx[o]) : LOCAL;
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            valid_o[i] = 1'b0;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (in_gnt[o][i]) valid_o[i] = 1'b1;
            end
            sel_vc_o[i] = valid_o[i] ? s1_vc[i] : '0;
        end
    end

    // A stage-1 pointer only moves when its winner also wins stage 2.
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_vc_arb
        round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
            .clk         (clk),
            .rst         (rst),
            .request_i   (elig[gi]),
            .update_i    (valid_o[gi]),
            .grant_o     (vc_gnt[gi]),
            .grant_idx_o (s1_vc[gi])
        );
    end

    for (genvar go = 0; go < PORT_NUM; go++) begin : g_out_arb
        round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
            .clk         (clk),
            .rst         (rst),
            .request_i   (in_req[go]),
            .update_i    (valid_flit_o[go]),
            .grant_o     (in_gnt[go]),
            .grant_idx_o (in_idx[go])
        );
    end

endmodule
